// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions for the 16-bit TSC multicycle CPU.
// State and next-PC select encodings used by fetch and control.
package instruction_fetch_unit_pkg;

    localparam int          WORD_SIZE = 16;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage and memory.
// The fetch stage is master; memory answers with data and inputReady.
interface instruction_fetch_unit_if #(
    parameter int WORD_SIZE = 16
);

    logic                 readM;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] data;
    logic                 inputReady;

    modport master (
        output readM,
        output address,
        input  data,
        input  inputReady
    );

    modport slave (
        input  readM,
        input  address,
        output data,
        output inputReady
    );

endinterface

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, page jump or PC-relative branch.
// Kept separate so the datapath can extend it with JAL/JPR targets.
module next_pc_calc #(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] inst,
    input  logic [1:0]           ctrlPc,
    output logic [WORD_SIZE-1:0] nextPc
);
    import instruction_fetch_unit_pkg::*;

    localparam logic [WORD_SIZE-1:0] ONE = 1;

    logic [WORD_SIZE-1:0] seqPc;
    logic [WORD_SIZE-1:0] brOffset;
    logic                 unusedInstBits;

    assign seqPc    = pc + ONE;
    assign brOffset = {{(WORD_SIZE-8){inst[7]}}, inst[7:0]};
    assign unusedInstBits = ^inst[WORD_SIZE-1:12];

    // The reserved select (2'b11) falls through to sequential.
    always_comb begin
        nextPc = seqPc;
        case (ctrlPc)
            PC_JMP:  nextPc = {pc[WORD_SIZE-1:12], inst[11:0]};
            PC_BR:   nextPc = seqPc + brOffset;
            default: nextPc = seqPc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the instruction-memory read handshake,
// holds the fetched word until retire and counts retired instructions.
module instruction_fetch_unit #(
    parameter int WORD_SIZE = instruction_fetch_unit_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC =
        instruction_fetch_unit_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instruction_fetch_unit_if.master mem,
    output logic [WORD_SIZE-1:0]  inst,
    output logic                  instValid,
    input  logic                  execDone,
    input  logic [1:0]            ctrlPc,
    input  logic                  halt,
    output logic [WORD_SIZE-1:0]  pc,
    output logic [WORD_SIZE-1:0]  num_inst,
    output logic                  halted
);
    import instruction_fetch_unit_pkg::*;

    localparam logic [WORD_SIZE-1:0] ONE = 1;

    fetch_state_t         state;
    fetch_state_t         stateNext;
    logic [WORD_SIZE-1:0] nextPc;
    logic                 fetchDone;
    logic                 retire;

    next_pc_calc #(
        .WORD_SIZE (WORD_SIZE)
    ) u_nextPc (
        .pc     (pc),
        .inst   (inst),
        .ctrlPc (ctrlPc),
        .nextPc (nextPc)
    );

    assign fetchDone   = (state == S_REQ) && mem.inputReady;
    assign retire      = (state == S_EXEC) && execDone;
    assign mem.address = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_REQ;
        end else begin
            state <= stateNext;
        end
    end

    // readM is gated by reset so an abandoned read is dropped at once.
    always_comb begin
        stateNext = state;
        mem.readM = 1'b0;
        instValid = 1'b0;
        halted    = 1'b0;
        unique case (state)
            S_REQ: begin
                mem.readM = reset_n;
                if (mem.inputReady) begin
                    stateNext = S_EXEC;
                end
            end
            S_EXEC: begin
                instValid = 1'b1;
                if (execDone) begin
                    stateNext = halt ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                stateNext = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            inst     <= '0;
            num_inst <= '0;
        end else begin
            if (fetchDone) begin
                inst <= mem.data;
            end
            if (retire) begin
                num_inst <= num_inst + ONE;
                if (!halt) begin
                    pc <= nextPc;
                end
            end
        end
    end

endmodule
